// File: rtl/cache_pkg.sv
// cache_pkg: shared geometry and controller state encoding
// for the instruction-cache refill path.
package cache_pkg;

  localparam int TAG_W   = 8;
  localparam int INDEX_W = 3;
  localparam int OFF_W   = 2;
  localparam int WAYS    = 4;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = TAG_W + INDEX_W + OFF_W;
  localparam int WAY_W   = $clog2(WAYS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_INVAL,
    S_REFILL,
    S_COMMIT,
    S_RESP
  } state_e;

endpackage

// File: rtl/icache_refill_ctrl_victim_sel.sv
// victim_sel: per-set round-robin pointers and the
// replacement choice for a missing line.
module victim_sel #(
  parameter int WAYS    = 4,
  parameter int INDEX_W = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WAYS-1:0]         way_valid,
  input  logic [INDEX_W-1:0]      index,
  input  logic                    advance,
  output logic [$clog2(WAYS)-1:0] victim
);

  localparam int WAY_W = $clog2(WAYS);
  localparam int SETS  = 2 ** INDEX_W;

  logic [WAY_W-1:0] r_ptr [SETS];
  logic [WAY_W-1:0] w_free;
  logic             w_all_valid;

  assign w_all_valid = &way_valid;

  // lowest-numbered invalid way, preferred over eviction
  always_comb begin
    w_free = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!way_valid[i]) w_free = WAY_W'(i);
    end
  end

  assign victim = w_all_valid ? r_ptr[index] : w_free;

  // pointer moves only when a valid line is evicted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) r_ptr[s] <= '0;
    end else if (advance && w_all_valid) begin
      r_ptr[index] <= r_ptr[index] + 1'b1;
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: tag lookup, victim choice and
// word-by-word block refill for the instruction cache.
module icache_refill_ctrl #(
  parameter int TAG_W   = cache_pkg::TAG_W,
  parameter int INDEX_W = cache_pkg::INDEX_W,
  parameter int OFF_W   = cache_pkg::OFF_W,
  parameter int WAYS    = cache_pkg::WAYS,
  parameter int DATA_W  = cache_pkg::DATA_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  input  logic [TAG_W+INDEX_W+OFF_W-1:0] req_addr,
  output logic                           req_ready,
  output logic [INDEX_W-1:0]             lookup_index,
  input  logic [WAYS-1:0]                way_valid,
  input  logic [WAYS-1:0]                way_tag_eq,
  output logic                           resp_valid,
  output logic                           resp_hit,
  output logic [$clog2(WAYS)-1:0]        resp_way,
  output logic                           mem_req,
  output logic [TAG_W+INDEX_W+OFF_W-1:0] mem_addr,
  input  logic                           mem_ack,
  input  logic [DATA_W-1:0]              mem_data,
  output logic                           memWrite,
  output logic [INDEX_W-1:0]             wr_index,
  output logic [WAYS-1:0]                wr_way,
  output logic [OFF_W-1:0]               wr_word,
  output logic [DATA_W-1:0]              wr_data,
  output logic                           valid_we,
  output logic                           valid_d
);

  import cache_pkg::state_e;
  import cache_pkg::S_IDLE;
  import cache_pkg::S_LOOKUP;
  import cache_pkg::S_INVAL;
  import cache_pkg::S_REFILL;
  import cache_pkg::S_COMMIT;
  import cache_pkg::S_RESP;

  localparam int AW = TAG_W + INDEX_W + OFF_W;
  localparam int WW = $clog2(WAYS);

  state_e             r_state;
  logic [TAG_W-1:0]   r_tag;
  logic [INDEX_W-1:0] r_index;
  logic [WW-1:0]      r_way;
  logic               r_hit;
  logic [OFF_W-1:0]   r_cnt;

  logic [WAYS-1:0]    w_hit_vec;
  logic               w_any_hit;
  logic [WW-1:0]      w_hit_way;
  logic [WW-1:0]      w_victim;
  logic               w_advance;
  logic               w_unused_off;

  assign w_unused_off = ^req_addr[OFF_W-1:0];

  assign w_hit_vec = way_valid & way_tag_eq;
  assign w_any_hit = |w_hit_vec;
  assign w_advance = (r_state == S_LOOKUP) && !w_any_hit;

  // lowest hitting way wins if several match
  always_comb begin
    w_hit_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (w_hit_vec[i]) w_hit_way = WW'(i);
    end
  end

  victim_sel #(
    .WAYS    (WAYS),
    .INDEX_W (INDEX_W)
  ) u_victim (
    .clk       (clk),
    .reset     (reset),
    .way_valid (way_valid),
    .index     (r_index),
    .advance   (w_advance),
    .victim    (w_victim)
  );

  // request sequencing: lookup, invalidate, refill, commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tag   <= '0;
      r_index <= '0;
      r_way   <= '0;
      r_hit   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_tag   <= req_addr[AW-1 -: TAG_W];
            r_index <= req_addr[OFF_W +: INDEX_W];
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_cnt <= '0;
          r_hit <= w_any_hit;
          if (w_any_hit) begin
            r_way   <= w_hit_way;
            r_state <= S_RESP;
          end else begin
            r_way   <= w_victim;
            r_state <= S_INVAL;
          end
        end
        S_INVAL: r_state <= S_REFILL;
        S_REFILL: begin
          if (mem_ack) begin
            r_cnt <= r_cnt + 1'b1;
            if (&r_cnt) r_state <= S_COMMIT;
          end
        end
        S_COMMIT: r_state <= S_RESP;
        S_RESP:   r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready    = (r_state == S_IDLE);
  assign lookup_index = r_index;
  assign resp_valid   = (r_state == S_RESP);
  assign resp_hit     = r_hit;
  assign resp_way     = r_way;
  assign mem_req      = (r_state == S_REFILL);
  assign mem_addr     = {r_tag, r_index, {OFF_W{1'b0}}};
  assign memWrite     = (r_state == S_REFILL) && mem_ack;
  assign wr_index     = r_index;
  assign wr_way       = WAYS'(1) << r_way;
  assign wr_word      = r_cnt;
  assign wr_data      = mem_data;
  assign valid_we     = (r_state == S_INVAL) ||
                        (r_state == S_COMMIT);
  assign valid_d      = (r_state == S_COMMIT);

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: cycle-level expectation queue fed by a
// transaction model of the cache, plus directed scenario pins.
module tb_icache_refill_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [12:0] req_addr;
  logic        req_ready;
  logic [2:0]  lookup_index;
  logic [3:0]  way_valid;
  logic [3:0]  way_tag_eq;
  logic        resp_valid;
  logic        resp_hit;
  logic [1:0]  resp_way;
  logic        mem_req;
  logic [12:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        memWrite;
  logic [2:0]  wr_index;
  logic [3:0]  wr_way;
  logic [1:0]  wr_word;
  logic [31:0] wr_data;
  logic        valid_we;
  logic        valid_d;

  icache_refill_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_ready    (req_ready),
    .lookup_index (lookup_index),
    .way_valid    (way_valid),
    .way_tag_eq   (way_tag_eq),
    .resp_valid   (resp_valid),
    .resp_hit     (resp_hit),
    .resp_way     (resp_way),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_data     (mem_data),
    .memWrite     (memWrite),
    .wr_index     (wr_index),
    .wr_way       (wr_way),
    .wr_word      (wr_word),
    .wr_data      (wr_data),
    .valid_we     (valid_we),
    .valid_d      (valid_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        rdy, rv, hit;
    bit [1:0]  way;
    bit        mreq;
    bit [12:0] maddr;
    bit        mw;
    bit [1:0]  word;
    bit [31:0] wdata;
    bit        vwe, vd;
    bit [3:0]  wway;
    bit [2:0]  widx;
    bit        chk_li;
    bit [2:0]  li;
  } exp_t;

  exp_t q[$];
  exp_t me;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_resp_cyc = 0;
  int mw_cnt   = 0;
  int mreq_cnt = 0;

  // the tag/valid/data arrays the controller writes into
  bit          arr_valid [8][4];
  logic [7:0]  arr_tag   [8][4];
  logic [31:0] arr_data  [8][4][4];
  logic [7:0]  cur_tag;

  // reference model of cache contents and replacement state
  bit          m_valid [8][4];
  logic [7:0]  m_tag   [8][4];
  int          m_rr    [8];
  int          last_way;
  bit          last_hit;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               n, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dfn(input logic [12:0] blk,
                                      input int w);
    return {3'b000, blk, 14'h2A5, 2'(w)};
  endfunction

  function automatic exp_t row0();
    exp_t e;
    e = '{default: 0};
    return e;
  endfunction

  function automatic exp_t row_idle();
    exp_t e;
    e = '{default: 0};
    e.rdy = 1'b1;
    return e;
  endfunction

  always_comb begin
    for (int w = 0; w < 4; w++) begin
      way_valid[w]  = arr_valid[lookup_index][w];
      way_tag_eq[w] = (arr_tag[lookup_index][w] == cur_tag);
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int w = 0; w < 4; w++) begin
      if (wr_way[w]) begin
        if (valid_we) arr_valid[wr_index][w] <= valid_d;
        if (memWrite) begin
          arr_tag[wr_index][w]           <= mem_addr[12:5];
          arr_data[wr_index][w][wr_word] <= wr_data;
        end
      end
    end
  end

  // per-cycle compare of DUT outputs against the expectation queue
  always @(negedge clk) begin
    if (resp_valid) last_resp_cyc = cyc;
    if (memWrite)   mw_cnt++;
    if (mem_req)    mreq_cnt++;
    if (q.size() != 0) begin
      me = q.pop_front();
      chk("req_ready",  req_ready,  me.rdy);
      chk("resp_valid", resp_valid, me.rv);
      chk("mem_req",    mem_req,    me.mreq);
      chk("memWrite",   memWrite,   me.mw);
      chk("valid_we",   valid_we,   me.vwe);
      if (me.vwe) begin
        chk("valid_d",  valid_d,  me.vd);
        chk("wr_way_v", wr_way,   me.wway);
        chk("wr_idx_v", wr_index, me.widx);
      end
      if (me.mw) begin
        chk("wr_word",  wr_word,  me.word);
        chk("wr_data",  wr_data,  me.wdata);
        chk("wr_way_d", wr_way,   me.wway);
        chk("wr_idx_d", wr_index, me.widx);
      end
      if (me.mreq) chk("mem_addr", mem_addr, me.maddr);
      if (me.rv) begin
        chk("resp_hit", resp_hit, me.hit);
        chk("resp_way", resp_way, me.way);
      end
      if (me.chk_li) chk("lookup_index", lookup_index, me.li);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ack();
    mem_ack  = 1'($urandom);
    mem_data = $urandom;
  endtask

  task automatic idle();
    tick();
    req_valid = 1'b0;
    rand_ack();
    q.push_back(row_idle());
  endtask

  task automatic preload(input int s, input logic [7:0] t0,
                         input logic [7:0] t1, input logic [7:0] t2,
                         input logic [7:0] t3);
    logic [7:0] t [4];
    t[0] = t0; t[1] = t1; t[2] = t2; t[3] = t3;
    for (int w = 0; w < 4; w++) begin
      arr_valid[s][w] = 1'b1; arr_tag[s][w] = t[w];
      m_valid[s][w]   = 1'b1; m_tag[s][w]   = t[w];
    end
  endtask

  task automatic do_req(input logic [12:0] addr,
                        input int w0, input int w1,
                        input int w2, input int w3,
                        input bit hold, input int abort_at,
                        output int lat);
    logic [7:0]  tag;
    logic [2:0]  idx;
    logic [12:0] blk;
    bit          hit, all;
    int          way, acc;
    int          wt [4];
    exp_t        e;
    wt[0] = w0; wt[1] = w1; wt[2] = w2; wt[3] = w3;
    tag = addr[12:5];
    idx = addr[4:2];
    blk = {addr[12:2], 2'b00};
    hit = 1'b0;
    way = 0;
    for (int w = 3; w >= 0; w--)
      if (m_valid[idx][w] && m_tag[idx][w] == tag) begin
        hit = 1'b1; way = w;
      end
    if (!hit) begin
      all = 1'b1;
      for (int w = 3; w >= 0; w--)
        if (!m_valid[idx][w]) begin all = 1'b0; way = w; end
      if (all) begin
        way = m_rr[idx];
        m_rr[idx] = (m_rr[idx] + 1) % 4;
      end
    end
    last_way = way;
    last_hit = hit;

    tick();
    req_valid = 1'b1; req_addr = addr; cur_tag = tag; rand_ack();
    q.push_back(row_idle());
    acc = cyc;

    tick();
    req_valid = hold; req_addr = 13'($urandom); rand_ack();
    e = row0(); e.chk_li = 1'b1; e.li = idx;
    q.push_back(e);

    if (hit) begin
      tick();
      req_addr = 13'($urandom); rand_ack();
      e = row0(); e.rv = 1'b1; e.hit = 1'b1; e.way = 2'(way);
      q.push_back(e);
    end else begin
      tick();
      req_addr = 13'($urandom); rand_ack();
      e = row0(); e.vwe = 1'b1; e.wway = 4'(1 << way); e.widx = idx;
      q.push_back(e);
      for (int w = 0; w < 4; w++) begin
        for (int i = 0; i < wt[w]; i++) begin
          tick();
          mem_ack = 1'b0; mem_data = $urandom;
          e = row0(); e.mreq = 1'b1; e.maddr = blk;
          q.push_back(e);
        end
        tick();
        mem_ack = 1'b1; mem_data = dfn(blk, w);
        e = row0(); e.mreq = 1'b1; e.maddr = blk; e.mw = 1'b1;
        e.word = 2'(w); e.wdata = dfn(blk, w);
        e.wway = 4'(1 << way); e.widx = idx;
        q.push_back(e);
        if (w == abort_at) begin
          tick();
          reset = 1'b1; req_valid = 1'b0; rand_ack();
          q.push_back(row_idle());
          tick(); rand_ack(); q.push_back(row_idle());
          tick(); reset = 1'b0; rand_ack(); q.push_back(row_idle());
          m_valid[idx][way] = 1'b0;
          for (int s = 0; s < 8; s++) m_rr[s] = 0;
          chk("abort_valid_bit", arr_valid[idx][way], 0);
          @(negedge clk); #1;
          lat = -1;
          return;
        end
      end
      tick();
      rand_ack();
      e = row0(); e.vwe = 1'b1; e.vd = 1'b1;
      e.wway = 4'(1 << way); e.widx = idx;
      q.push_back(e);
      tick();
      rand_ack();
      e = row0(); e.rv = 1'b1; e.way = 2'(way);
      q.push_back(e);
      m_valid[idx][way] = 1'b1;
      m_tag[idx][way]   = tag;
      chk("line_valid", arr_valid[idx][way], 1);
      chk("line_tag",   arr_tag[idx][way],   tag);
      for (int w = 0; w < 4; w++)
        chk("line_data", arr_data[idx][way][w], dfn(blk, w));
    end
    @(negedge clk); #1;
    lat = last_resp_cyc - acc;
  endtask

  initial begin
    int lat, mw0, mr0, g, ab;
    int wv [4];
    int exp_v [5];
    logic [12:0] a;
    bit hold;

    reset = 1'b0; req_valid = 1'b0; req_addr = '0;
    mem_ack = 1'b0; mem_data = '0; cur_tag = '0;
    for (int s = 0; s < 8; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < 4; w++) begin
        arr_valid[s][w] = 1'b0; arr_tag[s][w] = '0;
        m_valid[s][w] = 1'b0;   m_tag[s][w] = '0;
        for (int k = 0; k < 4; k++) arr_data[s][w][k] = '0;
      end
    end
    #1 reset = 1'b1;
    repeat (2) begin tick(); q.push_back(row_idle()); end
    tick(); reset = 1'b0; q.push_back(row_idle());
    idle();

    // cold miss at 0x123: set 0, way 0, zero-wait refill
    mw0 = mw_cnt;
    do_req(13'h123, 0, 0, 0, 0, 1'b0, -1, lat);
    chk("t1_hit", last_hit, 0);
    chk("t1_way", last_way, 0);
    chk("t1_latency", lat, 8);
    chk("t1_writes", mw_cnt - mw0, 4);

    // hit in way 2 of a full set
    preload(5, 8'h11, 8'h22, 8'h33, 8'h44);
    idle();
    mr0 = mreq_cnt;
    do_req({8'h33, 3'd5, 2'd1}, 0, 0, 0, 0, 1'b0, -1, lat);
    chk("t2_hit", last_hit, 1);
    chk("t2_way", last_way, 2);
    chk("t2_latency", lat, 2);
    chk("t2_no_mem_req", mreq_cnt - mr0, 0);

    // five misses into a full set walk the pointer and wrap
    preload(6, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    exp_v[0] = 0; exp_v[1] = 1; exp_v[2] = 2;
    exp_v[3] = 3; exp_v[4] = 0;
    for (int i = 0; i < 5; i++) begin
      idle();
      do_req({8'(8'hB0 + i), 3'd6, 2'd0}, 0, 0, 0, 0, 1'b0, -1, lat);
      chk("t3_victim", last_way, exp_v[i]);
      chk("t3_miss", last_hit, 0);
    end

    // three wait cycles between words 1 and 2
    idle();
    mw0 = mw_cnt;
    do_req({8'h07, 3'd1, 2'd2}, 0, 0, 3, 0, 1'b0, -1, lat);
    chk("t4_latency", lat, 11);
    chk("t4_writes", mw_cnt - mw0, 4);

    // request held high through a refill, then back-to-back hit
    idle();
    do_req({8'h5C, 3'd2, 2'd0}, 0, 1, 0, 0, 1'b1, -1, lat);
    chk("t5_latency", lat, 9);
    do_req({8'h5C, 3'd2, 2'd3}, 0, 0, 0, 0, 1'b0, -1, lat);
    chk("t5_hit", last_hit, 1);
    chk("t5_hit_latency", lat, 2);

    // reset after word 1 leaves the victim invalid and pointers cleared
    idle();
    do_req({8'h66, 3'd3, 2'd0}, 0, 0, 0, 0, 1'b0, 1, lat);
    chk("t6_abort_way", last_way, 0);
    idle();
    do_req({8'hC0, 3'd6, 2'd0}, 0, 0, 0, 0, 1'b0, -1, lat);
    chk("t6_ptr_reset", last_way, 0);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      g = $urandom_range(0, 2);
      for (int i = 0; i < g; i++) idle();
      a = {8'($urandom_range(0, 5)), 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3))};
      for (int w = 0; w < 4; w++)
        wv[w] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      hold = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 29) == 0) ? $urandom_range(0, 3) : -1;
      do_req(a, wv[0], wv[1], wv[2], wv[3], hold, ab, lat);
    end

    idle();
    idle();
    @(negedge clk); #1;
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
